// File: rtl/mem8x4_fifo_ctrl_pkg.sv
// Shared constants and types for the 8x4 memory FIFO controller.
package mem8x4_fifo_ctrl_pkg;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int CNT_MAX = 10;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        NOP,
        WR,
        RD
    } mem_op_t;

endpackage

// File: rtl/mem8x4.sv
// 8-entry x 4-bit single-port memory: clocked write, combinational read.
module mem8x4 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem8x4_fifo_ctrl_arb.sv
// Two-requester arbiter; priority flips to the loser on each conflict.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_w,
    input  logic req_r,
    output logic gnt_w,
    output logic gnt_r
);

    logic prio;

    always_comb begin
        gnt_w = req_w && (!req_r || !prio);
        gnt_r = req_r && (!req_w || prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (req_w && req_r) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/mem8x4_fifo_ctrl.sv
// FIFO controller in front of a single-port 8x4 memory: wbuf -> mem -> out reg.
module mem8x4_fifo_ctrl #(
    parameter int WIDTH = mem8x4_fifo_ctrl_pkg::WIDTH,
    parameter int DEPTH = mem8x4_fifo_ctrl_pkg::DEPTH,
    parameter int AW    = mem8x4_fifo_ctrl_pkg::AW
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH-1:0]                       out_data,
    output logic [mem8x4_fifo_ctrl_pkg::CNT_W-1:0] count,
    output logic [AW-1:0]                          mem_addr,
    output logic [WIDTH-1:0]                       mem_wdata,
    output logic                                   mem_wr,
    input  logic [WIDTH-1:0]                       mem_rdata
);

    import mem8x4_fifo_ctrl_pkg::*;

    localparam logic [AW:0] MEM_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             wbuf_valid;
    logic [WIDTH-1:0] wbuf_data;
    mem_op_t          op_q;

    logic write_want;
    logic refill_want;
    logic wr_gnt;
    logic rd_gnt;
    logic accept;
    logic pop;

    // A read already in flight will fill the output register; don't stack another.
    assign write_want  = wbuf_valid && (mem_cnt < MEM_FULL);
    assign refill_want = (mem_cnt != '0) && (op_q != RD)
                         && (!out_valid || out_ready);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_w (write_want),
        .req_r (refill_want),
        .gnt_w (wr_gnt),
        .gnt_r (rd_gnt)
    );

    assign in_ready = !wbuf_valid || wr_gnt;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign count = CNT_W'(mem_cnt) + CNT_W'(wbuf_valid)
                 + CNT_W'(out_valid) + CNT_W'(op_q == RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            wbuf_valid <= 1'b0;
            wbuf_data  <= '0;
            op_q       <= NOP;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                wbuf_valid <= 1'b1;
                wbuf_data  <= in_data;
            end else if (wr_gnt) begin
                wbuf_valid <= 1'b0;
            end

            if (wr_gnt) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= wbuf_data;
                mem_wr    <= 1'b1;
                op_q      <= WR;
                wr_ptr    <= wr_ptr + 1'b1;
                mem_cnt   <= mem_cnt + 1'b1;
            end else if (rd_gnt) begin
                mem_addr <= rd_ptr;
                mem_wr   <= 1'b0;
                op_q     <= RD;
                rd_ptr   <= rd_ptr + 1'b1;
                mem_cnt  <= mem_cnt - 1'b1;
            end else begin
                mem_wr <= 1'b0;
                op_q   <= NOP;
            end

            if (op_q == RD) begin
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
